// File: rtl/branch_pkg.sv
// Shared types and constants for the chunked branch comparator.
`timescale 1ns/1ps
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // BLT and BGE order their operands as two's complement, everything else unsigned
    function automatic logic isSignedCmp(input logic [2:0] funct3);
        return (funct3 == F3_BLT) || (funct3 == F3_BGE);
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational magnitude compare of one CHUNK-bit operand slice.
`timescale 1ns/1ps
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // Unsigned ordering of the slice; exactly one flag is always high
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/branch_compare.sv
// Multi-cycle branch comparator: walks the operands MSB slice first and
// stops at the first slice that differs, or at the last slice when equal.
`timescale 1ns/1ps
module branch_compare
    import branch_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct_3,
    input  logic        branch_in,
    output logic        done,
    output logic        more,
    output logic        even,
    output logic        less,
    output logic        branch_out
);

    localparam int NSLICE = 32 / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_rs1;
    logic [31:0]     r_rs2;
    logic [IDXW-1:0] r_idx;
    logic            w_accept;
    logic            w_signed;
    logic            w_gt;
    logic            w_eq;
    logic            w_lt;
    logic            w_lastSlice;
    logic            w_decide;

    assign w_accept    = start && ready;
    assign w_signed    = isSignedCmp(funct_3);
    assign w_lastSlice = (r_idx == '0);
    assign w_decide    = (r_state == CMP) && (!w_eq || w_lastSlice);

    // The captured operands are shifted up each cycle, so the slice under
    // test is always the top CHUNK bits
    cmp_chunk #(.CHUNK(CHUNK)) u_cmpChunk (
        .a  (r_rs1[31 -: CHUNK]),
        .b  (r_rs2[31 -: CHUNK]),
        .gt (w_gt),
        .eq (w_eq),
        .lt (w_lt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a start in DONE is deliberately not seen
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start)    w_nextState = CMP;
            CMP:     if (w_decide) w_nextState = DONE;
            DONE:                  w_nextState = IDLE;
            default:               w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        ready = (r_state == IDLE);
        done  = (r_state == DONE);
    end

    // Operand capture, slice walk and result flags; flipping bit 31 turns
    // signed order into unsigned order so one comparator serves both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_idx      <= '0;
            more       <= 1'b0;
            even       <= 1'b0;
            less       <= 1'b0;
            branch_out <= 1'b0;
        end else if (w_accept) begin
            r_rs1      <= {rs1[31] ^ w_signed, rs1[30:0]};
            r_rs2      <= {rs2[31] ^ w_signed, rs2[30:0]};
            r_idx      <= LAST_IDX;
            more       <= 1'b0;
            even       <= 1'b0;
            less       <= 1'b0;
            branch_out <= branch_in;
        end else if (r_state == CMP) begin
            if (w_decide) begin
                more <= w_gt;
                even <= w_eq;
                less <= w_lt;
            end else begin
                r_rs1 <= r_rs1 << CHUNK;
                r_rs2 <= r_rs2 << CHUNK;
                r_idx <= r_idx - IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_compare.sv
// Bench for branch_compare: one instance per legal CHUNK, directed vectors
// on the CHUNK=8 instance plus a random sweep on all four.
`timescale 1ns/1ps
module tb_branch_compare;

    logic        clk;
    logic        rst_n     [4];
    logic        start     [4];
    logic        ready     [4];
    logic [31:0] rs1       [4];
    logic [31:0] rs2       [4];
    logic [2:0]  funct3    [4];
    logic        branchIn  [4];
    logic        done      [4];
    logic        more      [4];
    logic        even      [4];
    logic        less      [4];
    logic        branchOut [4];

    int nChecks = 0;
    int nFails  = 0;

    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        br;
        logic [2:0]  expFlags;
        int          expLat;
    } vec_t;

    vec_t vecs [8];
    logic [2:0] codes [6];

    for (genvar g = 0; g < 4; g++) begin : gDut
        branch_compare #(.CHUNK(4 << g)) uDut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .start      (start[g]),
            .ready      (ready[g]),
            .rs1        (rs1[g]),
            .rs2        (rs2[g]),
            .funct_3    (funct3[g]),
            .branch_in  (branchIn[g]),
            .done       (done[g]),
            .more       (more[g]),
            .even       (even[g]),
            .less       (less[g]),
            .branch_out (branchOut[g])
        );
    end

    // Free-running clock shared by every instance
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference result straight from the branch rules: signed or unsigned
    // ordering, latency from the position of the highest differing bit
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  input int chunk, output logic [2:0] flags, output int lat);
        logic [31:0] diff;
        int msb;
        diff = a ^ b;
        msb = -1;
        if (f == 3'b100 || f == 3'b101)
            flags = {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
        else
            flags = {a > b, a == b, a < b};
        for (int i = 0; i < 32; i++) if (diff[i]) msb = i;
        lat = (msb < 0) ? (32 / chunk + 1) : ((31 - msb) / chunk + 2);
    endfunction

    // One full compare on instance u; operands are scrambled every cycle
    // after the accept to show the result only depends on captured values
    task automatic applyStimulus(input int u, input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f, input logic br,
                                 input logic [2:0] expFlags, input int expLat);
        int lat;
        bit quietOk;
        lat = -1;
        quietOk = 1;
        @(negedge clk);
        checkOutput({tag, ".readyBeforeAccept"}, ready[u], 1);
        rs1[u] = a; rs2[u] = b; funct3[u] = f; branchIn[u] = br; start[u] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start[u]    = 1'b0;
            rs1[u]      = $urandom;
            rs2[u]      = $urandom;
            funct3[u]   = 3'($urandom);
            branchIn[u] = ~br;
            if (done[u]) begin
                lat = n;
                break;
            end
            if (ready[u] || more[u] || even[u] || less[u]) quietOk = 0;
        end
        checkOutput({tag, ".quietDuringCmp"}, quietOk, 1);
        if (lat < 0) begin
            checkOutput({tag, ".doneTimeout"}, done[u], 1);
        end else begin
            checkOutput({tag, ".latency"}, lat, expLat);
            checkOutput({tag, ".flags"}, {more[u], even[u], less[u]}, expFlags);
            checkOutput({tag, ".readyInDone"}, ready[u], 0);
            checkOutput({tag, ".branchOut"}, branchOut[u], br);
            @(negedge clk);
            checkOutput({tag, ".donePulse"}, done[u], 0);
            checkOutput({tag, ".idleAfterDone"}, ready[u], 1);
            checkOutput({tag, ".flagsHeld"}, {more[u], even[u], less[u]}, expFlags);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [2:0]  expF;
        int          expL;
        int          doneAt;
        int          lat2;
        bit          sawDone;

        codes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        vecs[0] = '{32'h8000_0000, 32'h0000_0001, 3'b100, 1'b1, FLAG_LT, 2};
        vecs[1] = '{32'h8000_0000, 32'h0000_0001, 3'b110, 1'b0, FLAG_GT, 2};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1, FLAG_EQ, 5};
        vecs[3] = '{32'h0000_0010, 32'h0000_0020, 3'b110, 1'b0, FLAG_LT, 5};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 1'b1, FLAG_LT, 2};
        vecs[5] = '{32'h0000_1200, 32'h0000_1100, 3'b001, 1'b0, FLAG_GT, 4};
        vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 1'b1, FLAG_GT, 2};
        vecs[7] = '{32'h0000_0001, 32'h0000_0000, 3'b111, 1'b1, FLAG_GT, 5};

        for (int u = 0; u < 4; u++) begin
            rst_n[u] = 1'b0; start[u] = 1'b0; rs1[u] = '0; rs2[u] = '0;
            funct3[u] = '0; branchIn[u] = 1'b1;
        end

        #12;
        for (int u = 0; u < 4; u++) begin
            checkOutput($sformatf("reset[%0d].ready", u), ready[u], 1);
            checkOutput($sformatf("reset[%0d].done", u), done[u], 0);
            checkOutput($sformatf("reset[%0d].flags", u), {more[u], even[u], less[u]}, 3'b000);
            checkOutput($sformatf("reset[%0d].branchOut", u), branchOut[u], 0);
        end
        @(negedge clk);
        for (int u = 0; u < 4; u++) rst_n[u] = 1'b1;

        $display("[TB] directed vectors, CHUNK=8");
        for (int i = 0; i < 8; i++)
            applyStimulus(1, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].br,
                          vecs[i].expFlags, vecs[i].expLat);

        $display("[TB] start held high with changing operands");
        doneAt = -1;
        a = '0; b = '0; f = '0;
        @(negedge clk);
        rs1[1] = 32'h0000_0010; rs2[1] = 32'h0000_0020; funct3[1] = 3'b000; start[1] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (done[1] && doneAt < 0) doneAt = n;
            if (n == 5) checkOutput("holdStart.flags1", {more[1], even[1], less[1]}, FLAG_LT);
            if (n == 6) begin
                checkOutput("holdStart.noAcceptInDone", ready[1], 1);
                checkOutput("holdStart.doneCleared", done[1], 0);
            end
            if (n == 7) begin
                checkOutput("holdStart.secondAccept", ready[1], 0);
                checkOutput("holdStart.flagsCleared", {more[1], even[1], less[1]}, 3'b000);
            end
            rs1[1] = $urandom;
            rs2[1] = $urandom;
            funct3[1] = codes[$urandom_range(0, 5)];
            if (n == 6) begin a = rs1[1]; b = rs2[1]; f = funct3[1]; end
            if (n == 7) start[1] = 1'b0;
        end
        checkOutput("holdStart.latency1", doneAt, 5);
        model(a, b, f, 8, expF, expL);
        lat2 = -1;
        if (done[1]) lat2 = 1;
        for (int m = 2; m <= 40 && lat2 < 0; m++) begin
            @(negedge clk);
            if (done[1]) lat2 = m;
        end
        checkOutput("holdStart.latency2", lat2, expL);
        checkOutput("holdStart.flags2", {more[1], even[1], less[1]}, expF);
        @(negedge clk);

        $display("[TB] reset during compare");
        @(negedge clk);
        rs1[1] = 32'h1234_5678; rs2[1] = 32'h1234_5678; funct3[1] = 3'b000; branchIn[1] = 1'b1; start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        checkOutput("midReset.ready", ready[1], 1);
        checkOutput("midReset.done", done[1], 0);
        checkOutput("midReset.flags", {more[1], even[1], less[1]}, 3'b000);
        checkOutput("midReset.branchOut", branchOut[1], 0);
        sawDone = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == 2) rst_n[1] = 1'b1;
            if (done[1]) sawDone = 1;
        end
        checkOutput("midReset.noDone", sawDone, 0);
        applyStimulus(1, "afterReset", 32'h0000_0100, 32'h0000_0200, 3'b100, 1'b1, FLAG_LT, 4);

        $display("[TB] random sweep over all CHUNK values");
        for (int u = 0; u < 4; u++) begin
            for (int i = 0; i < 40; i++) begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = $urandom;
                    1: b = a;
                    2: b = a ^ (32'h1 << $urandom_range(0, 31));
                    default: b = a ^ 32'h8000_0000;
                endcase
                f = codes[$urandom_range(0, 5)];
                model(a, b, f, 4 << u, expF, expL);
                applyStimulus(u, $sformatf("rand[%0d].%0d", u, i), a, b, f, 1'($urandom), expF, expL);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global time limit so the bench always ends on its own
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/branch_compare.md
BRANCH_COMPARE -- requirements
Module: branch_compare

Interface
REQ-001 The block SHALL have parameter CHUNK, default 8, meaning operand bits compared per cycle; legal values 4, 8, 16, 32.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, compare request; accepted only when start && ready.
REQ-005 The block SHALL have port ready, output, 1, high only in IDLE.
REQ-006 The block SHALL have ports rs1 and rs2, input, 32 each, operands; sampled on accept only.
REQ-007 The block SHALL have port funct_3, input, 3, branch funct3 code; sampled on accept.
REQ-008 The block SHALL have port branch_in, input, 1, branch-instruction flag; sampled on accept.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking valid result.
REQ-010 The block SHALL have ports more, even, less, output, 1 each, rs1>rs2, rs1==rs2, rs1<rs2; consumed by the branch decision unit.
REQ-011 The block SHALL have port branch_out, output, 1, registered copy of branch_in, valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, CMP, DONE; IDLE->CMP on accept, CMP->DONE on decision, DONE->IDLE unconditionally after one cycle.
REQ-013 The compare SHALL be signed when funct_3 is 100 or 101, and unsigned for all other codes.
REQ-014 For a signed compare, bit 31 of both captured operands SHALL be inverted before comparison; this reduces signed order to unsigned order.
REQ-015 The CMP state SHALL examine one CHUNK-bit slice per cycle, starting from the MSB slice and moving down through a slice index.
REQ-016 Decision SHALL occur in the first slice where rs1 and rs2 differ (greater or less taken from that slice), or in the last slice when all slices are equal (even).
REQ-017 Latency SHALL be: done high k+1 cycles after the accept cycle, where k = slices examined; worst case 32/CHUNK+1.
REQ-018 Exactly one of more/even/less SHALL be high from the done cycle until the next accepted start.
REQ-019 On accept, more/even/less SHALL clear to 0; they SHALL remain 0 throughout CMP.
REQ-020 start while ready is low SHALL be ignored, with no effect on state, operands or outputs.
REQ-021 Changes to rs1/rs2/funct_3 after accept SHALL NOT affect the in-flight result.
REQ-022 done SHALL be high only in DONE; start in the DONE cycle SHALL NOT be accepted.
REQ-023 The slice index SHALL NOT wrap; the last slice always forces DONE.

Reset
REQ-024 When rst_n is low, the block SHALL immediately enter IDLE with done=0, more=0, even=0, less=0, branch_out=0, and ready=1.
REQ-025 Reset asserted mid-CMP SHALL abort the compare with no done pulse; the first accept after release SHALL behave as from power-up.

Structure
REQ-026 Package branch_pkg SHALL hold the state enum and the funct3 constants (F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111).
REQ-027 The combinational slice comparator SHALL be a sub-module, cmp_chunk (inputs a, b of width CHUNK; outputs gt, eq, lt).

Verification
REQ-028 CHUNK=8, rs1=32'h8000_0000, rs2=32'h0000_0001, funct_3=100 -> done 2 cycles after accept; less=1.
REQ-029 Same operands, funct_3=110 -> done 2 cycles after accept; more=1.
REQ-030 rs1=rs2=32'h1234_5678, funct_3=000 -> done 5 cycles after accept; even=1; ready low for 5 cycles.
REQ-031 rs1=32'h0000_0010, rs2=32'h0000_0020, start held high continuously with operands changing every cycle -> second accept only after return to IDLE; first result less=1, unaffected by the changing operands.
REQ-032 rst_n pulsed low during the second CMP cycle -> outputs 0 immediately, no done pulse; next compare correct.
REQ-033 Random sweep with CHUNK in {4,8,16,32}, all six funct3 codes -> flags match a signed/unsigned golden model, and latency equals the first differing slice count +1.
